// File: rtl/adc_spi_pkg.sv
// Shared types and defaults for the ADC SPI sweep sequencer.
package adc_spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int unsigned DEF_CLK_DIV   = 25;
  localparam int unsigned DEF_RES       = 12;
  localparam int unsigned DEF_NULL_BITS = 3;
  localparam int unsigned DEF_NUM_CH    = 4;
  localparam int unsigned DEF_CS_GAP    = 1;

  // Upper bound on channels; next_ch returns MAX_CH when no channel qualifies.
  localparam int unsigned MAX_CH = 8;

  // Lowest set bit of mask at index >= first, or MAX_CH if none.
  function automatic logic [3:0] next_ch(input logic [MAX_CH-1:0] mask,
                                         input logic [3:0]        first);
    next_ch = 4'(MAX_CH);
    for (int i = int'(MAX_CH) - 1; i >= 0; i--) begin
      if (mask[i] && (4'(i) >= first)) next_ch = 4'(i);
    end
  endfunction

endpackage

// File: rtl/adc_sclk_gen.sv
// SCLK divider: toggles sclk every CLK_DIV clk cycles while enabled and flags
// the cycle in which each rising/falling transition is being registered.
module adc_sclk_gen
  import adc_spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic enable_i,
  input  logic clear_i,
  output logic sclk_o,
  output logic rise_c,
  output logic fall_c
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             sclk_q, sclk_d;
  logic             wrap_c;

  assign wrap_c = enable_i && (cnt_q == DIV_W'(CLK_DIV - 1));
  assign rise_c = wrap_c && !sclk_q;
  assign fall_c = wrap_c && sclk_q;
  assign sclk_o = sclk_q;

  always_comb begin
    cnt_d  = cnt_q;
    sclk_d = sclk_q;
    if (clear_i) begin
      cnt_d  = '0;
      sclk_d = 1'b0;
    end else if (enable_i) begin
      if (wrap_c) begin
        cnt_d  = '0;
        sclk_d = ~sclk_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

endmodule

// File: rtl/adc_spi_seq.sv
// ADC SPI sweep sequencer: converts each enabled channel in turn over a shared SCLK/MISO bus.
// Define ADC_SPI_SEQ_MISO_INV_EN to store every kept MISO sample inverted.
module adc_spi_seq
  import adc_spi_pkg::*;
#(
  parameter  int unsigned CLK_DIV   = DEF_CLK_DIV,
  parameter  int unsigned RES       = DEF_RES,
  parameter  int unsigned NULL_BITS = DEF_NULL_BITS,
  parameter  int unsigned NUM_CH    = DEF_NUM_CH,
  parameter  int unsigned CS_GAP    = DEF_CS_GAP,
  localparam int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_n,
  input  logic              cont,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic              miso,
  output logic              sclk,
  output logic [NUM_CH-1:0] cs_n,
  output logic [RES-1:0]    data,
  output logic [CH_W-1:0]   data_ch,
  output logic              data_valid,
  output logic              busy,
  output logic              done
);

  localparam int unsigned TOT_BITS = NULL_BITS + RES;
  localparam int unsigned BC_W     = 5;
  localparam int unsigned GAP_LEN  = 2 * CS_GAP * CLK_DIV;
  localparam int unsigned GAP_W    = $clog2(GAP_LEN);

  state_e            state_q, state_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [RES-1:0]    sh_q, sh_d;
  logic [NUM_CH-1:0] cs_n_q, cs_n_d;
  logic [RES-1:0]    data_q, data_d;
  logic [CH_W-1:0]   data_ch_q, data_ch_d;
  logic              data_valid_q, data_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              restart_q, restart_d;

  logic              smp;
  logic              rise_c, fall_c;
  logic [3:0]        first_ch, nxt_ch;

`ifdef ADC_SPI_SEQ_MISO_INV_EN
  assign smp = ~miso;
`else
  assign smp = miso;
`endif

  adc_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .clk      (clk),
    .reset    (reset),
    .enable_i (state_q == SHIFT),
    .clear_i  (state_q != SHIFT),
    .sclk_o   (sclk),
    .rise_c   (rise_c),
    .fall_c   (fall_c)
  );

  assign first_ch = next_ch(MAX_CH'(ch_mask), 4'd0);
  assign nxt_ch   = next_ch(MAX_CH'(mask_q), 4'(ch_q) + 4'd1);

  // Next-state and datapath; cs_n changes on the same edge that enters/leaves SHIFT.
  always_comb begin
    state_d      = state_q;
    mask_d       = mask_q;
    ch_d         = ch_q;
    bit_cnt_d    = '0;
    gap_cnt_d    = '0;
    sh_d         = sh_q;
    cs_n_d       = cs_n_q;
    data_d       = data_q;
    data_ch_d    = data_ch_q;
    data_valid_d = 1'b0;
    busy_d       = busy_q;
    done_d       = 1'b0;
    restart_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!start_n || restart_q) begin
          mask_d = ch_mask;
          busy_d = 1'b1;
          if (first_ch < 4'(MAX_CH)) begin
            ch_d    = CH_W'(first_ch);
            cs_n_d  = ~(NUM_CH'(1) << first_ch);
            state_d = SHIFT;
          end else begin
            state_d = DONE;
          end
        end
      end
      SHIFT: begin
        bit_cnt_d = bit_cnt_q;
        if (rise_c) begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q >= BC_W'(NULL_BITS)) sh_d = RES'({sh_q, smp});
        end
        if (fall_c && (bit_cnt_q == BC_W'(TOT_BITS))) begin
          cs_n_d       = '1;
          data_d       = sh_q;
          data_ch_d    = ch_q;
          data_valid_d = 1'b1;
          state_d      = GAP;
        end
      end
      GAP: begin
        gap_cnt_d = gap_cnt_q + 1'b1;
        if (gap_cnt_q == GAP_W'(GAP_LEN - 1)) begin
          if (nxt_ch < 4'(MAX_CH)) begin
            ch_d    = CH_W'(nxt_ch);
            cs_n_d  = ~(NUM_CH'(1) << nxt_ch);
            state_d = SHIFT;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
        if (cont) restart_d = 1'b1;
        else      busy_d    = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      mask_q       <= '0;
      ch_q         <= '0;
      bit_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      sh_q         <= '0;
      cs_n_q       <= '1;
      data_q       <= '0;
      data_ch_q    <= '0;
      data_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      restart_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      ch_q         <= ch_d;
      bit_cnt_q    <= bit_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      sh_q         <= sh_d;
      cs_n_q       <= cs_n_d;
      data_q       <= data_d;
      data_ch_q    <= data_ch_d;
      data_valid_q <= data_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      restart_q    <= restart_d;
    end
  end

  assign cs_n       = cs_n_q;
  assign data       = data_q;
  assign data_ch    = data_ch_q;
  assign data_valid = data_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_adc_spi_seq.sv
// Bench for adc_spi_seq: ADC MISO model feeds words per conversion; expected
// results are queued at each chip-select fall and checked on data_valid.
module tb_adc_spi_seq;

  localparam int unsigned CLK_DIV   = 2;
  localparam int unsigned RES       = 12;
  localparam int unsigned NULL_BITS = 3;
  localparam int unsigned NUM_CH    = 4;
  localparam int unsigned CS_GAP    = 1;
  localparam int unsigned TOT       = NULL_BITS + RES;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_n;
  logic        cont;
  logic [3:0]  ch_mask;
  logic        miso = 1'b0;
  logic        sclk;
  logic [3:0]  cs_n;
  logic [11:0] data;
  logic [1:0]  data_ch;
  logic        data_valid;
  logic        busy;
  logic        done;

  int n_chk = 0;
  int n_bad = 0;
  int cyc   = 0;

  int          cs_fall_cyc[$];
  int          cs_fall_ch[$];
  int          dv_cyc[$];
  int          done_cyc[$];
  int          done_busy[$];
  logic [11:0] word_q[$];
  logic [11:0] exp_data_q[$];
  logic [1:0]  exp_ch_q[$];

  logic [11:0] cur_word     = '0;
  int          fall_cnt     = 0;
  int          rise_cnt     = 0;
  int          idle_viol    = 0;
  int          overlap_viol = 0;
  logic        prev_sclk    = 1'b0;
  logic [3:0]  prev_cs      = 4'hF;

  adc_spi_seq #(
    .CLK_DIV   (CLK_DIV),
    .RES       (RES),
    .NULL_BITS (NULL_BITS),
    .NUM_CH    (NUM_CH),
    .CS_GAP    (CS_GAP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start_n    (start_n),
    .cont       (cont),
    .ch_mask    (ch_mask),
    .miso       (miso),
    .sclk       (sclk),
    .cs_n       (cs_n),
    .data       (data),
    .data_ch    (data_ch),
    .data_valid (data_valid),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] exp_of(input logic [11:0] w);
`ifdef ADC_SPI_SEQ_MISO_INV_EN
    return ~w;
`else
    return w;
`endif
  endfunction

  function automatic int q_at(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  // ADC model and scoreboard: null bits read as 1, then the word MSB first; bits change after SCLK falls.
  always @(negedge clk) begin
    int k;
    if (sclk && !prev_sclk) rise_cnt++;
    if (!sclk && prev_sclk) fall_cnt++;
    if (&cs_n) fall_cnt = 0;
    if (sclk && (&cs_n)) idle_viol++;
    if ($countones(~cs_n) > 1) overlap_viol++;
    for (int c = 0; c < int'(NUM_CH); c++) begin
      if (prev_cs[c] && !cs_n[c]) begin
        cs_fall_cyc.push_back(cyc);
        cs_fall_ch.push_back(c);
        cur_word = (word_q.size() > 0) ? word_q.pop_front() : 12'h000;
        exp_data_q.push_back(exp_of(cur_word));
        exp_ch_q.push_back(2'(c));
      end
    end
    k = fall_cnt;
    if (k < int'(NULL_BITS))  miso = 1'b1;
    else if (k < int'(TOT))   miso = cur_word[int'(RES) - 1 - (k - int'(NULL_BITS))];
    else                      miso = 1'b0;
    if (data_valid) begin
      dv_cyc.push_back(cyc);
      if (exp_data_q.size() == 0) begin
        chk("dv_unexpected", 32'd1, 32'd0);
      end else begin
        chk("data", 32'(data), 32'(exp_data_q.pop_front()));
        chk("data_ch", 32'(data_ch), 32'(exp_ch_q.pop_front()));
      end
      chk("dv_cs_high", 32'(cs_n), 32'hF);
      chk("dv_sclk_low", 32'(sclk), 32'd0);
    end
    if (done) begin
      done_cyc.push_back(cyc);
      done_busy.push_back(int'(busy));
    end
    prev_sclk = sclk;
    prev_cs   = cs_n;
  end

  task automatic clear_logs();
    cs_fall_cyc.delete();
    cs_fall_ch.delete();
    dv_cyc.delete();
    done_cyc.delete();
    done_busy.delete();
  endtask

  task automatic start_sweep(input logic [3:0] m, output int t);
    ch_mask = m;
    start_n = 1'b0;
    t = cyc + 1;
    @(negedge clk);
    start_n = 1'b1;
    chk("busy_at_start", 32'(busy), 32'd1);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_seen"}, 32'(done), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0;
    int n;
    int rbase;
    int r;
    logic ps;

    reset   = 1'b0;
    start_n = 1'b1;
    cont    = 1'b0;
    ch_mask = 4'h0;
    repeat (3) @(negedge clk);
    chk("rst_cs_n", 32'(cs_n), 32'hF);
    chk("rst_sclk", 32'(sclk), 32'd0);
    chk("rst_data", 32'(data), 32'd0);
    chk("rst_data_ch", 32'(data_ch), 32'd0);
    chk("rst_dv", 32'(data_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Single channel conversion with a stray start_n pulse mid-sweep.
    clear_logs();
    word_q.push_back(12'hA5C);
    start_sweep(4'b0001, t0);
    repeat (20) @(negedge clk);
    start_n = 1'b0;
    @(negedge clk);
    start_n = 1'b1;
    wait_done("t1", 300);
    chk("t1_cs_falls", 32'(cs_fall_cyc.size()), 32'd1);
    chk("t1_cs_fall_cyc", 32'(q_at(cs_fall_cyc, 0)), 32'(t0));
    chk("t1_dv_count", 32'(dv_cyc.size()), 32'd1);
    chk("t1_dv_cyc", 32'(q_at(dv_cyc, 0)), 32'(t0 + 60));
    chk("t1_done_cyc", 32'(q_at(done_cyc, 0)), 32'(t0 + 65));
    repeat (10) @(negedge clk);
    chk("t1_data_hold", 32'(data), 32'(exp_of(12'hA5C)));
    chk("t1_data_ch_hold", 32'(data_ch), 32'd0);
    chk("t1_busy_idle", 32'(busy), 32'd0);

    // Sparse mask 1010; mask change mid-sweep must not matter.
    clear_logs();
    word_q.push_back(12'h0F0);
    word_q.push_back(12'hBEE);
    start_sweep(4'b1010, t0);
    repeat (5) @(negedge clk);
    ch_mask = 4'b1111;
    wait_done("t2", 400);
    chk("t2_cs_falls", 32'(cs_fall_cyc.size()), 32'd2);
    chk("t2_first_ch", 32'(q_at(cs_fall_ch, 0)), 32'd1);
    chk("t2_second_ch", 32'(q_at(cs_fall_ch, 1)), 32'd3);
    chk("t2_gap", 32'(q_at(cs_fall_cyc, 1) - q_at(dv_cyc, 0)), 32'd4);
    chk("t2_dv_count", 32'(dv_cyc.size()), 32'd2);
    chk("t2_done_cyc", 32'(q_at(done_cyc, 0)), 32'(t0 + 129));
    repeat (5) @(negedge clk);

    // Empty mask: single done, no bus activity.
    clear_logs();
    rbase = rise_cnt;
    start_sweep(4'b0000, t0);
    repeat (20) @(negedge clk);
    chk("t3_done_count", 32'(done_cyc.size()), 32'd1);
    chk("t3_done_cyc", 32'(q_at(done_cyc, 0)), 32'(t0 + 1));
    chk("t3_cs_falls", 32'(cs_fall_cyc.size()), 32'd0);
    chk("t3_sclk_rises", 32'(rise_cnt - rbase), 32'd0);
    chk("t3_busy", 32'(busy), 32'd0);

    // Continuous mode, cont cleared during the third sweep.
    clear_logs();
    word_q.push_back(12'h001);
    word_q.push_back(12'hFFF);
    word_q.push_back(12'h5A5);
    cont = 1'b1;
    start_sweep(4'b0001, t0);
    n = 0;
    while (dv_cyc.size() < 2 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("t4_two_dv_seen", 32'(dv_cyc.size() >= 2), 32'd1);
    repeat (15) @(negedge clk);
    cont = 1'b0;
    n = 0;
    while (done_cyc.size() < 3 && n < 400) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("t4_dv_count", 32'(dv_cyc.size()), 32'd3);
    chk("t4_dv0_cyc", 32'(q_at(dv_cyc, 0)), 32'(t0 + 60));
    chk("t4_period1", 32'(q_at(dv_cyc, 1) - q_at(dv_cyc, 0)), 32'd66);
    chk("t4_period2", 32'(q_at(dv_cyc, 2) - q_at(dv_cyc, 1)), 32'd66);
    chk("t4_done_count", 32'(done_cyc.size()), 32'd3);
    chk("t4_busy_done0", 32'(q_at(done_busy, 0)), 32'd1);
    chk("t4_busy_done1", 32'(q_at(done_busy, 1)), 32'd1);
    chk("t4_busy_done2", 32'(q_at(done_busy, 2)), 32'd0);
    repeat (10) @(negedge clk);
    chk("t4_busy_after", 32'(busy), 32'd0);
    chk("t4_dv_after", 32'(dv_cyc.size()), 32'd3);

    // Reset at the 8th SCLK rising edge, then a clean conversion.
    clear_logs();
    word_q.push_back(12'h777);
    start_sweep(4'b0001, t0);
    r  = 0;
    n  = 0;
    ps = sclk;
    while (r < 8 && n < 200) begin
      @(negedge clk);
      if (sclk && !ps) r++;
      ps = sclk;
      n++;
    end
    chk("t5_edge8_seen", 32'(r), 32'd8);
    reset = 1'b0;
    #1;
    chk("t5_rst_cs_n", 32'(cs_n), 32'hF);
    chk("t5_rst_sclk", 32'(sclk), 32'd0);
    chk("t5_rst_data", 32'(data), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    exp_data_q.delete();
    exp_ch_q.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    chk("t5_no_dv", 32'(dv_cyc.size()), 32'd0);
    chk("t5_no_done", 32'(done_cyc.size()), 32'd0);
    word_q.push_back(12'h3C3);
    start_sweep(4'b0001, t0);
    wait_done("t5", 300);
    chk("t5_dv_count", 32'(dv_cyc.size()), 32'd1);
    chk("t5_dv_cyc", 32'(q_at(dv_cyc, 0)), 32'(t0 + 60));

    chk("sclk_idle_viol", 32'(idle_viol), 32'd0);
    chk("cs_overlap_viol", 32'(overlap_viol), 32'd0);
    chk("exp_left", 32'(exp_data_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/adc_spi_seq.md
ADC_SPI_SEQ -- requirements
Module: adc_spi_seq

Interface
REQ-001 SHALL have parameter CLK_DIV, 25, SCLK half-period in clk cycles (≥2); 40 MHz gives 800 kHz SCLK.
REQ-002 SHALL have parameter RES, 12, ADC result width in bits (1..16).
REQ-003 SHALL have parameter NULL_BITS, 3, SCLK rising edges discarded before the MSB (0..7).
REQ-004 SHALL have parameter NUM_CH, 4, number of ADCs sharing SCLK/MISO, each with its own chip select (1..8).
REQ-005 SHALL have parameter CS_GAP, 1, minimum all-CS-high time between conversions, in SCLK periods (≥1).
REQ-006 SHALL have ports: clk in 1 system clock; reset in 1 asynchronous active-low reset.
REQ-007 SHALL have ports: start_n in 1 active-low sweep request; cont in 1 auto-restart enable; ch_mask in NUM_CH channel enable.
REQ-008 SHALL have ports: miso in 1 shared ADC data; sclk out 1 SPI clock; cs_n out NUM_CH per-channel chip selects, active low.
REQ-009 SHALL have ports: data out RES result; data_ch out clog2(NUM_CH) (min 1) result channel; data_valid out 1 one-cycle result strobe; busy out 1 sweep active; done out 1 one-cycle sweep-complete strobe.

Function
REQ-010 SHALL clock all logic on clk; sclk SHALL be a registered output, never used as a clock.
REQ-011 SHALL implement states IDLE, SHIFT, GAP, DONE.
REQ-012 IDLE: if start_n=0, latch ch_mask, select the lowest enabled channel, and go to SHIFT next cycle; busy=1 from that cycle.
REQ-013 IDLE with start_n=0 and latched mask all zero: go to DONE, assert no cs_n, emit done one cycle later.
REQ-014 SHIFT entry at cycle T: cs_n[ch]=0, sclk=0, divider cleared; the Nth sclk rising edge SHALL occur at T+(2N-1)*CLK_DIV and the Nth falling edge at T+2N*CLK_DIV.
REQ-015 miso SHALL be sampled in the clk cycle sclk goes 0->1; the first NULL_BITS samples are discarded, the next RES samples shift in MSB first.
REQ-016 At T+2*(NULL_BITS+RES)*CLK_DIV: cs_n[ch]=1, data/data_ch updated, data_valid=1 for one cycle; then go to GAP.
REQ-017 GAP SHALL last 2*CS_GAP*CLK_DIV cycles with all cs_n high and sclk low, then go to SHIFT for the next higher enabled channel, or to DONE if none remain.
REQ-018 DONE SHALL last one cycle with done=1; then if cont=1, re-latch ch_mask and restart as in REQ-012 without start_n, else return to IDLE with busy=0.
REQ-019 start_n SHALL be ignored outside IDLE; ch_mask changes SHALL have no effect until the next latch.
REQ-020 At most one cs_n bit SHALL be low at any time; sclk SHALL be low whenever all cs_n are high.
REQ-021 data and data_ch SHALL hold their last values between data_valid strobes.
REQ-022 Clearing cont during a sweep SHALL complete the current sweep and return to IDLE.

Reset
REQ-023 reset=0 SHALL immediately force IDLE, cs_n all ones, sclk=0, data=0, data_ch=0, data_valid=0, busy=0, done=0, and clear the divider and bit counter.
REQ-024 Reset mid-conversion SHALL discard partial data; no data_valid or done strobe SHALL be issued for it.

Configuration
REQ-025 With ADC_SPI_SEQ_MISO_INV_EN defined, each kept sample SHALL be stored inverted (~miso), for boards with an inverting MISO buffer.
REQ-026 Without ADC_SPI_SEQ_MISO_INV_EN, samples SHALL be stored unmodified.

Structure
REQ-027 Package adc_spi_pkg SHALL hold the state encoding (IDLE/SHIFT/GAP/DONE) and the parameter default constants.
REQ-028 The SCLK divider and edge-strobe generator SHALL be the sub-module adc_sclk_gen (inputs: enable, clear; outputs: sclk, rise strobe, fall strobe).

Verification
REQ-029 CLK_DIV=2, NULL_BITS=3, RES=12, mask=0001, MISO model returns 0xA5C: cs_n[0] falls at T; data=0xA5C, data_ch=0 and data_valid at T+60; done 5 cycles later (GAP=4, DONE=1).
REQ-030 Same setup, mask=1010: conversions on ch1 then ch3 only; ch3 cs_n falls 4 cycles after ch1 data_valid; never two cs_n low.
REQ-031 mask=0000, start_n pulsed low: no cs_n or sclk activity; done pulses exactly once.
REQ-032 cont=1, mask=0001, MISO returns 0x001 then 0xFFF: back-to-back sweeps, data_valid every 66 cycles with correct values; cont cleared mid-sweep -> busy falls after that sweep's done.
REQ-033 reset asserted at sclk edge 8 of a conversion: cs_n=all 1, sclk=0 in the same cycle; no data_valid; a new start after reset converts normally.
REQ-034 Build with ADC_SPI_SEQ_MISO_INV_EN, MISO returns 0x0F0: data=0xF0F.
